// File: rtl/rv_muldiv_pkg.sv
// Shared encodings for the iterative RISC-V M-extension multiply/divide unit.
// Holds the func3 opcodes, the FSM state encoding and the XLEN legality check.
package rv_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/rv_muldiv_iter.sv
// Iterative RISC-V multiply/divide unit: one shared shift/add-subtract datapath
// operating on unsigned magnitudes, with a fast path for trivially known results.
module rv_muldiv_iter
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data
);

    localparam int CNT_W  = $clog2(XLEN / BITS_PER_CYC) + 1;
    localparam int N_FULL = XLEN / BITS_PER_CYC;
    localparam int N_WORD = 32 / BITS_PER_CYC;

    if (!xlen_legal(XLEN) || ((32 % BITS_PER_CYC) != 0)) begin : g_bad_param
        $error("rv_muldiv_iter: illegal XLEN or BITS_PER_CYC");
    end

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    state_e            state_r, state_n, state_step_s;
    op_e               op_r;
    logic              word_r, neg_r;
    logic [XLEN-1:0]   a_r, hi_r, lo_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              word_s, neg1_s, neg2_s, neg_in_s, fast_s;
    logic              div0_s, ovf_s, wmulh_s;
    logic [XLEN-1:0]   mask_s, min_s, op1w_s, op2w_s, mag1_s, mag2_s;
    logic [XLEN-1:0]   a_in_s, lo_in_s, fast_val_s, fast_res_s;
    logic [XLEN-1:0]   hi_s, lo_s, res_s, val_s;
    logic [XLEN+1:0]   x_s, y_s, add_s;
    logic [2*XLEN-1:0] prod_s;
    logic              q_s;

    // Request decode: operand masking, magnitudes, sign of result and fast-path detection.
    always_comb begin
        word_s  = (XLEN == 64) ? req_word : 1'b0;
        mask_s  = word_s ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}};
        min_s   = word_s ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        op1w_s  = req_op1 & mask_s;
        op2w_s  = req_op2 & mask_s;
        neg1_s  = ((req_op == OP_MULH) || (req_op == OP_MULHSU) || (req_op == OP_DIV) ||
                   (req_op == OP_REM)) && (word_s ? req_op1[31] : req_op1[XLEN-1]);
        neg2_s  = ((req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM)) &&
                  (word_s ? req_op2[31] : req_op2[XLEN-1]);
        mag1_s  = neg1_s ? ((~op1w_s + XLEN'(1)) & mask_s) : op1w_s;
        mag2_s  = neg2_s ? ((~op2w_s + XLEN'(1)) & mask_s) : op2w_s;
        neg_in_s = (req_op[2] && req_op[1]) ? neg1_s : (neg1_s ^ neg2_s);
        a_in_s  = req_op[2] ? mag2_s : mag1_s;
        // Dividend bits are consumed MSB-first, so word dividends are pre-aligned to the top.
        lo_in_s = req_op[2] ? (word_s ? (mag1_s << (XLEN - 32)) : mag1_s) : mag2_s;

        div0_s  = req_op[2] && (op2w_s == '0);
        ovf_s   = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                  (op1w_s == min_s) && (op2w_s == mask_s);
        wmulh_s = word_s && !req_op[2] && (req_op[1:0] != 2'b00);
        fast_s  = div0_s || ovf_s || wmulh_s;
        if (wmulh_s) begin
            fast_val_s = '0;
        end else if (div0_s) begin
            fast_val_s = req_op[1] ? op1w_s : mask_s;
        end else if (ovf_s) begin
            fast_val_s = req_op[1] ? '0 : op1w_s;
        end else begin
            fast_val_s = '0;
        end
        fast_res_s = word_s ? sext32(fast_val_s[31:0]) : fast_val_s;
    end

    // Shared iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        hi_s  = hi_r;
        lo_s  = lo_r;
        x_s   = '0;
        y_s   = '0;
        add_s = '0;
        q_s   = 1'b0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            if (op_r[2]) begin
                x_s = {1'b0, hi_s, lo_s[XLEN-1]};
                y_s = ~{2'b00, a_r};
            end else begin
                x_s = {2'b00, hi_s};
                y_s = lo_s[0] ? {2'b00, a_r} : '0;
            end
            add_s = x_s + y_s + {{(XLEN+1){1'b0}}, op_r[2]};
            if (op_r[2]) begin
                q_s  = ~add_s[XLEN+1];
                hi_s = q_s ? add_s[XLEN-1:0] : x_s[XLEN-1:0];
                lo_s = {lo_s[XLEN-2:0], q_s};
            end else begin
                q_s  = 1'b0;
                hi_s = add_s[XLEN:1];
                lo_s = {add_s[0], lo_s[XLEN-1:1]};
            end
        end
    end

    // Final result selection and sign correction from the last iteration's outputs.
    always_comb begin
        prod_s = neg_r ? (~{hi_s, lo_s} + (2*XLEN)'(1)) : {hi_s, lo_s};
        case (op_r)
            OP_MUL:                        val_s = word_s_r_low();
            OP_MULH, OP_MULHSU, OP_MULHU:  val_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               val_s = neg_r ? (~(lo_s & (word_r ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}})) + XLEN'(1))
                                                         : (lo_s & (word_r ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}}));
            OP_REM, OP_REMU:               val_s = neg_r ? (~hi_s + XLEN'(1)) : hi_s;
            default:                       val_s = '0;
        endcase
        res_s = word_r ? sext32(val_s[31:0]) : val_s;
    end

    // Word products land in the upper half of lo; full-width products fill lo.
    function automatic logic [XLEN-1:0] word_s_r_low();
        return word_r ? XLEN'(lo_s[XLEN-1 -: 32]) : prod_s[XLEN-1:0];
    endfunction

    // Next-state logic; flush wins over every other condition.
    always_comb begin
        state_step_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_step_s = fast_s ? S_DONE : S_CALC;
                end else begin
                    state_step_s = S_IDLE;
                end
            end
            S_CALC:  state_step_s = (cnt_r == CNT_W'(1)) ? S_DONE : S_CALC;
            S_DONE:  state_step_s = resp_ready ? S_IDLE : S_DONE;
            default: state_step_s = S_IDLE;
        endcase
        state_n   = flush ? S_IDLE : state_step_s;
        req_ready = (state_r == S_IDLE) && !flush && !rst;
    end

    // State, datapath and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            op_r       <= OP_MUL;
            word_r     <= 1'b0;
            neg_r      <= 1'b0;
            a_r        <= '0;
            hi_r       <= '0;
            lo_r       <= '0;
            cnt_r      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            state_r <= state_n;
            case (state_r)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_r       <= op_e'(req_op);
                        word_r     <= word_s;
                        neg_r      <= neg_in_s;
                        a_r        <= a_in_s;
                        hi_r       <= '0;
                        lo_r       <= lo_in_s;
                        cnt_r      <= word_s ? CNT_W'(N_WORD) : CNT_W'(N_FULL);
                        resp_valid <= fast_s;
                        resp_data  <= fast_s ? fast_res_s : '0;
                    end
                end
                S_CALC: begin
                    hi_r  <= hi_s;
                    lo_r  <= lo_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        resp_valid <= 1'b1;
                        resp_data  <= res_s;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_data  <= '0;
                end
            endcase
            if (flush) begin
                resp_valid <= 1'b0;
                resp_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rv_muldiv_iter.sv
// Self-checking bench for rv_muldiv_iter (XLEN=64, one bit per cycle): directed
// corner cases plus random operations checked against a plain-arithmetic model.
module tb_rv_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, req_word, resp_valid, resp_ready;
    logic [2:0]  req_op;
    logic [63:0] req_op1, req_op2, resp_data;
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    rv_muldiv_iter #(.XLEN(64), .BITS_PER_CYC(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_word(req_word), .req_op1(req_op1), .req_op2(req_op2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural reference straight from the ISA definition.
    function automatic void ref_model(input logic [2:0] op, input logic w,
                                      input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] r, output logic fast);
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         a32, b32, r32;
        logic [127:0]        p;
        fast = 1'b0;
        r    = 64'd0;
        sa = a; sb = b;
        a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
        if (w) begin
            r32 = 32'd0;
            case (op)
                3'd0: r32 = a32 * b32;
                3'd1, 3'd2, 3'd3: fast = 1'b1;
                3'd4: if (b32 == 32'd0) begin r32 = 32'hFFFF_FFFF; fast = 1'b1; end
                      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin r32 = a32; fast = 1'b1; end
                      else r32 = sa32 / sb32;
                3'd5: if (b32 == 32'd0) begin r32 = 32'hFFFF_FFFF; fast = 1'b1; end
                      else r32 = a32 / b32;
                3'd6: if (b32 == 32'd0) begin r32 = a32; fast = 1'b1; end
                      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin r32 = 32'd0; fast = 1'b1; end
                      else r32 = sa32 % sb32;
                default: if (b32 == 32'd0) begin r32 = a32; fast = 1'b1; end
                         else r32 = a32 % b32;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (op)
                3'd0: r = a * b;
                3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
                3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
                3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
                3'd4: if (b == 64'd0) begin r = '1; fast = 1'b1; end
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = a; fast = 1'b1; end
                      else r = sa / sb;
                3'd5: if (b == 64'd0) begin r = '1; fast = 1'b1; end
                      else r = a / b;
                3'd6: if (b == 64'd0) begin r = a; fast = 1'b1; end
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = 64'd0; fast = 1'b1; end
                      else r = sa % sb;
                default: if (b == 64'd0) begin r = a; fast = 1'b1; end
                         else r = a % b;
            endcase
        end
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // One full transaction: offer, wait for result, hold for `hold` cycles, handshake.
    task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input int hold,
                         output logic [63:0] d, output int lat);
        logic [63:0] exp;
        logic        fast;
        int          exp_lat;
        ref_model(op, w, a, b, exp, fast);
        exp_lat = fast ? 1 : (w ? 33 : 65);
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_word = w; req_op1 = a; req_op2 = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            chk("data_zero_busy", resp_data, 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        d = resp_data;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", d, exp);
        chk("ready_low_done", 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_data", resp_data, exp);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("after_hs_valid", 64'(resp_valid), 64'd0);
        chk("after_hs_data", resp_data, 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        int          lat;
        logic        seen;

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 3'd0; req_word = 1'b0; req_op1 = 64'd0; req_op2 = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_data", resp_data, 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        do_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, d, lat);
        chk("mul_7x-3_data", d, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_7x-3_lat", 64'(lat), 64'd65);

        do_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, d, lat);
        chk("div_ovf_data", d, 64'h8000_0000_0000_0000);
        chk("div_ovf_lat", 64'(lat), 64'd1);
        do_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, d, lat);
        chk("rem_ovf_data", d, 64'd0);

        do_op(3'd5, 1'b0, 64'd5, 64'd0, 0, d, lat);
        chk("divu_zero_data", d, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("divu_zero_lat", 64'(lat), 64'd1);
        do_op(3'd7, 1'b0, 64'd5, 64'd0, 0, d, lat);
        chk("remu_zero_data", d, 64'd5);

        do_op(3'd4, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 0, d, lat);
        chk("divw_data", d, 64'hFFFF_FFFF_C000_0000);
        chk("divw_lat", 64'(lat), 64'd33);

        // Flush during the tenth CALC cycle.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_word = 1'b0; req_op1 = 64'd123; req_op2 = 64'd456;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush_ready", 64'(req_ready), 64'd1);
        chk("flush_valid", 64'(resp_valid), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("flush_no_resp", 64'(seen), 64'd0);

        do_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, d, lat);
        chk("mulhu_ones_data", d, 64'hFFFF_FFFF_FFFF_FFFE);

        do_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5, d, lat);
        chk("div_hold_data", d, 64'hFFFF_FFFF_FFFF_FFF2);

        // Reset in the middle of a division aborts it silently.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_word = 1'b0; req_op1 = 64'd1000; req_op2 = 64'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_valid", 64'(resp_valid), 64'd0);
        chk("rst_mid_data", resp_data, 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ready_after", 64'(req_ready), 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("rst_mid_no_resp", 64'(seen), 64'd0);

        for (int k = 0; k < 40; k++) begin
            do_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(),
                  $urandom_range(0, 2), d, lat);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
